// File: rtl/scan_chain_controller.sv
// Byte-stream master for the memory-bank scan chain: serialises valid/ready load
// bytes onto scan_in and packs the bits sampled on scan_out back into bytes.
module scan_chain_controller #(
   parameter int CHAIN_LEN = 144,
   parameter int CNT_WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mode,
   output logic       busy,
   output logic       done,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       scan_enable,
   output logic       scan_in,
   input  logic       scan_out,
   output logic [2:0] state_dbg
);

   // Handshakes: a byte moves on a rising edge where valid && ready; the sender
   // holds data stable while valid is high and ready is low.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT_IN = 3'd1,
      S_SHIFT   = 3'd2,
      S_OUT     = 3'd3,
      S_FIN     = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic                 mode_q;
   logic [CNT_WIDTH-1:0] remaining;
   logic [2:0]           bit_cnt;
   logic [7:0]           tx_sh;
   logic [7:0]           rx_q;
   logic                 last_bit;

   // A byte ends after eight shifts or when the chain runs out mid-byte.
   assign last_bit = (bit_cnt == 3'd7) || (remaining == CNT_WIDTH'(1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start) state_d = mode ? S_SHIFT : S_WAIT_IN;
         S_WAIT_IN: if (in_valid) state_d = S_SHIFT;
         S_SHIFT:   if (last_bit) state_d = S_OUT;
         S_OUT: begin
            if (out_ready) begin
               if (remaining != '0) state_d = mode_q ? S_SHIFT : S_WAIT_IN;
               else                 state_d = S_FIN;
            end
         end
         S_FIN:     state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy        = (state_q == S_WAIT_IN) || (state_q == S_SHIFT) || (state_q == S_OUT);
      done        = (state_q == S_FIN);
      in_ready    = (state_q == S_WAIT_IN);
      out_valid   = (state_q == S_OUT);
      scan_enable = (state_q == S_SHIFT);
      scan_in     = 1'b0;
      if (state_q == S_SHIFT) scan_in = mode_q ? scan_out : tx_sh[0];
      out_data    = rx_q;
      state_dbg   = state_q;
   end

   // Datapath: rx_q is cleared whenever a new byte begins shifting, so the
   // unsampled high bits of a short final byte read as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q    <= 1'b0;
         remaining <= '0;
         bit_cnt   <= '0;
         tx_sh     <= '0;
         rx_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mode_q    <= mode;
                  remaining <= CNT_WIDTH'(CHAIN_LEN);
                  bit_cnt   <= '0;
                  if (mode) rx_q <= '0;
               end
            end
            S_WAIT_IN: begin
               if (in_valid) begin
                  tx_sh   <= in_data;
                  rx_q    <= '0;
                  bit_cnt <= '0;
               end
            end
            S_SHIFT: begin
               rx_q[bit_cnt] <= scan_out;
               tx_sh         <= tx_sh >> 1;
               remaining     <= remaining - CNT_WIDTH'(1);
               bit_cnt       <= bit_cnt + 3'd1;
            end
            S_OUT: begin
               if (out_ready && (remaining != '0) && mode_q) begin
                  rx_q    <= '0;
                  bit_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_scan_chain_controller.sv
// Directed bench for scan_chain_controller: a 144-bit and a 12-bit instance,
// each driving a behavioural chain model, exercised through one muxed driver.
module tb_scan_chain_controller;

   localparam int LEN_A = 144;
   localparam int LEN_B = 12;
   localparam int CYC_LIMIT = 3000;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1, start = 1'b0, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic       sel = 1'b0;
   logic [7:0] in_data = 8'h00;

   logic       busy_a, done_a, in_ready_a, out_valid_a, se_a, si_a, so_a;
   logic [7:0] od_a;
   logic [2:0] st_a;
   logic       busy_b, done_b, in_ready_b, out_valid_b, se_b, si_b, so_b;
   logic [7:0] od_b;
   logic [2:0] st_b;

   function automatic logic [LEN_A-1:0] init_chain_a();
      logic [LEN_A-1:0] c;
      c = '0;
      for (int j = 0; j < LEN_A / 8; j++) c[8*j +: 8] = 8'(8'h80 + j);
      return c;
   endfunction

   logic [LEN_A-1:0] chain_a = init_chain_a();
   logic [LEN_B-1:0] chain_b = '0;

   // Chain models: bit 0 is the tail feeding scan_out.
   always @(posedge clk) if (se_a) chain_a <= {si_a, chain_a[LEN_A-1:1]};
   always @(posedge clk) if (se_b) chain_b <= {si_b, chain_b[LEN_B-1:1]};
   assign so_a = chain_a[0];
   assign so_b = chain_b[0];

   scan_chain_controller #(.CHAIN_LEN(LEN_A), .CNT_WIDTH(8)) dut_a (
      .clk(clk), .rst(rst), .start(start & ~sel), .mode(mode),
      .busy(busy_a), .done(done_a),
      .in_data(in_data), .in_valid(in_valid & ~sel), .in_ready(in_ready_a),
      .out_data(od_a), .out_valid(out_valid_a), .out_ready(out_ready & ~sel),
      .scan_enable(se_a), .scan_in(si_a), .scan_out(so_a), .state_dbg(st_a)
   );

   scan_chain_controller #(.CHAIN_LEN(LEN_B), .CNT_WIDTH(4)) dut_b (
      .clk(clk), .rst(rst), .start(start & sel), .mode(mode),
      .busy(busy_b), .done(done_b),
      .in_data(in_data), .in_valid(in_valid & sel), .in_ready(in_ready_b),
      .out_data(od_b), .out_valid(out_valid_b), .out_ready(out_ready & sel),
      .scan_enable(se_b), .scan_in(si_b), .scan_out(so_b), .state_dbg(st_b)
   );

   logic       busy, done, in_ready, out_valid, scan_enable, scan_in;
   logic [7:0] out_data;
   logic [2:0] state_dbg;
   assign busy        = sel ? busy_b      : busy_a;
   assign done        = sel ? done_b      : done_a;
   assign in_ready    = sel ? in_ready_b  : in_ready_a;
   assign out_valid   = sel ? out_valid_b : out_valid_a;
   assign scan_enable = sel ? se_b        : se_a;
   assign scan_in     = sel ? si_b        : si_a;
   assign out_data    = sel ? od_b        : od_a;
   assign state_dbg   = sel ? st_b        : st_a;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] tx_q[$];
   logic [7:0] exp_q[$];
   int se_cnt, done_cnt, last_byte_se, got;
   bit ir_seen, stall_bad, aborted;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_tx(input logic [7:0] base, input int n);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(8'(base + i));
   endtask

   task automatic fill_exp(input logic [7:0] base, input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(8'(base + i));
   endtask

   // ---------------- driver ----------------
   task automatic run_xfer(input string name, input logic m, input int nbytes, input bit gaps,
                           input int stall_byte, input int rst_byte, input bit pulse);
      int cyc = 0, tail = 0, in_idx = 0, byte_se = 0, stall_left = 10;
      int chain_len;
      logic [7:0] held = 8'h00;
      chain_len = sel ? LEN_B : LEN_A;
      se_cnt = 0; done_cnt = 0; got = 0; last_byte_se = 0;
      ir_seen = 0; stall_bad = 0; aborted = 0;
      start = 1'b1; mode = m;
      @(negedge clk);
      start = 1'b0;
      while (tail < 3 && cyc < CYC_LIMIT) begin
         cyc++;
         if (scan_enable) begin se_cnt++; byte_se++; end
         if (done) done_cnt++;
         if (done_cnt > 0) tail++;
         if (m && in_ready) ir_seen = 1;
         if (in_ready && scan_enable) stall_bad = 1;
         if (rst_byte >= 0 && got == rst_byte && scan_enable && byte_se == 3) begin
            rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            check("rst_ctl_outputs", {busy, done, in_ready, out_valid, scan_enable, scan_in}, 6'b0);
            check("rst_state_idle", state_dbg, 3'd0);
            check("rst_out_data", out_data, 8'h00);
            aborted = 1;
            break;
         end
         start = pulse && (cyc == 20 || cyc == 100);
         if (in_ready && in_idx < tx_q.size() && !(gaps && $urandom_range(0, 2) == 0)) begin
            in_valid = 1'b1; in_data = tx_q[in_idx]; in_idx++;
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid) begin
            if (got == stall_byte && stall_left > 0) begin
               if (stall_left == 10) held = out_data;
               else if (out_data !== held || scan_enable) stall_bad = 1;
               out_ready = 1'b0; stall_left--;
            end else begin
               out_ready = 1'b1;
               if (exp_q.size() > 0)
                  check($sformatf("%s_byte%0d", name, got), out_data, exp_q.pop_front());
               got++; last_byte_se = byte_se; byte_se = 0;
            end
         end else begin
            out_ready = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      if (!aborted) begin
         check({name, "_done_pulses"}, done_cnt, 1);
         check({name, "_shift_cycles"}, se_cnt, chain_len);
         check({name, "_out_bytes"}, got, nbytes);
         check({name, "_end_idle"}, {busy, state_dbg}, 4'd0);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(negedge clk);
      check("reset_a", {busy, done, in_ready, out_valid, scan_enable, scan_in, state_dbg, out_data}, 0);
      sel = 1'b1;
      #1;
      check("reset_b", {busy, done, in_ready, out_valid, scan_enable, scan_in, state_dbg, out_data}, 0);
      sel = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Load 0x01..0x12; the out stream carries the preloaded 0x80..0x91.
      fill_tx(8'h01, 18); fill_exp(8'h80, 18);
      run_xfer("load", 1'b0, 18, 0, -1, -1, 0);
      check("chain_tail_byte", chain_a[7:0], 8'h01);
      check("chain_head_byte", chain_a[LEN_A-1 -: 8], 8'h12);

      for (int r = 0; r < 2; r++) begin
         fill_exp(8'h01, 18);
         run_xfer($sformatf("readback%0d", r), 1'b1, 18, 0, -1, -1, 0);
         check($sformatf("readback%0d_in_ready", r), ir_seen, 0);
      end

      // Partial chain of 12 bits.
      sel = 1'b1;
      tx_q.delete(); tx_q.push_back(8'hA5); tx_q.push_back(8'hF3);
      exp_q.delete(); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      run_xfer("part_load", 1'b0, 2, 0, -1, -1, 0);
      check("part_last_byte_shifts", last_byte_se, 4);
      exp_q.delete(); exp_q.push_back(8'hA5); exp_q.push_back(8'h03);
      run_xfer("part_rb", 1'b1, 2, 0, -1, -1, 0);
      sel = 1'b0;
      @(negedge clk);

      // Backpressure: random input gaps and a 10-cycle output stall.
      fill_tx(8'h01, 18); fill_exp(8'h01, 18);
      run_xfer("bp_load", 1'b0, 18, 1, 3, -1, 0);
      check("bp_stall_frozen", stall_bad, 0);
      fill_exp(8'h01, 18);
      run_xfer("bp_rb", 1'b1, 18, 0, -1, -1, 0);

      // Reset during the third shift of byte 5, then a clean load/readback.
      fill_tx(8'h40, 18); exp_q.delete();
      run_xfer("abort", 1'b0, 18, 0, -1, 4, 0);
      check("abort_taken", aborted, 1);
      fill_tx(8'h01, 18); exp_q.delete();
      run_xfer("reload", 1'b0, 18, 0, -1, -1, 0);
      fill_exp(8'h01, 18);
      run_xfer("reload_rb", 1'b1, 18, 0, -1, -1, 0);

      // start pulsed while busy must be ignored.
      fill_tx(8'h21, 18); fill_exp(8'h01, 18);
      run_xfer("pulse_load", 1'b0, 18, 0, -1, -1, 1);
      fill_exp(8'h21, 18);
      run_xfer("pulse_rb", 1'b1, 18, 0, -1, -1, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
